qspi_psram_ctrl: RTL
====================

# qspi_psram_ctrl

Synthesizable QSPI PSRAM initiator that drives `sck_o`, `cs_on` and four tri-state IO lines toward an external quad-SPI PSRAM, such as the bench PSRAM model.

- After reset it issues the Quad Mode Enable command (0x35).
- It then serves single read (0xEB) and write (0x38) requests of 1–4 bytes from an on-chip req/ack port.
- It sits between the SoC memory bus adapter and the PSRAM pads.

## Interface
Parameters:
- `CS_GAP`, default 2: number of sck pulses issued with `cs_on` high after every transaction. Minimum 1, because the device resets its command decoder on an sck edge while deselected.
- `DUMMY_CYCLES`, default 6: number of dummy sck cycles between the address and read data.

Ports:
- `clk_i` input 1: system clock. All logic runs on the rising edge.
- `rst_in` input 1: reset, synchronous, active-low.
- `req_i` input 1: request valid. Held high, with all request fields stable, until `ack_o`.
- `we_i` input 1: 1 = write, 0 = read.
- `adr_i` input 24: byte address of the first byte.
- `len_i` input 2: byte count minus 1 (0..3 gives 1..4 bytes).
- `wdat_i` input 32: write data. Byte i is in [8i+7:8i] and goes to address `adr_i`+i.
- `ack_o` output 1: one-cycle completion pulse.
- `rdat_o` output 32: read data, valid from `ack_o` until the next ack. Byte i is in [8i+7:8i]; bytes beyond `len_i` are 0.
- `sck_o` output 1: serial clock, at `clk_i`/2 while active.
- `cs_on` output 1: chip select, active-low.
- `io_o` output 4: IO output values, with `io_o[3]` as the MSB of a nibble.
- `io_oe_o` output 4: per-line output enable. The pad drives `io_o[k]` when `io_oe_o[k]` is 1.
- `io_i` input 4: IO pad input values.

## Operation
- **SPI clock period.** One SPI clock = 2 `clk_i` cycles:
  - L phase: `sck_o`=0, and `io_o` / `io_oe_o` update.
  - H phase: `sck_o`=1.
- **Device sampling.** The device samples on sck rise and changes its read data just after sck rise.
- **Controller read sampling.** The controller registers `io_i` on the `clk_i` edge that raises `sck_o`. It therefore samples the nibble the device has driven since the previous sck rise.
- **States:** INIT, IDLE, CMD, ADR, DUMMY, WDATA, RDATA, GAP.
- **INIT** (entered on reset):
  - `cs_on`=0, `io_oe_o`=0001.
  - Shifts 0x35 MSB first on `io_o[0]` over 8 sck.
  - Then goes to GAP, and GAP returns to IDLE.
  - Requests are not accepted before the first IDLE.
- **IDLE:**
  - `cs_on`=1, `sck_o`=0, `io_oe_o`=0000.
  - When `req_i`=1, latch `we_i`, `adr_i`, `len_i` and `wdat_i`, clear `rdat_o`, and go to CMD.
- **CMD:**
  - `io_oe_o`=0001.
  - Sends 0x38 (write) or 0xEB (read) serially, MSB first on `io_o[0]`, over 8 sck.
- **ADR:**
  - `io_oe_o`=1111.
  - Sends 6 nibbles, MSB nibble first (address bits [23:20] first).
  - Then goes to WDATA if writing, otherwise DUMMY.
- **DUMMY:** `io_oe_o`=0000 for `DUMMY_CYCLES` sck. Then goes to RDATA.
- **WDATA:**
  - `io_oe_o`=1111.
  - Sends 2 nibbles per byte, high nibble first, byte 0 first, for `len_i`+1 bytes.
- **RDATA:**
  - `io_oe_o`=0000.
  - Receives 2 nibbles per byte, high nibble first, into byte lane i.
- **End of WDATA/RDATA:**
  - `cs_on` goes high in the next L phase, and `ack_o` pulses in that same cycle.
  - Then enters GAP.
- **GAP:** `cs_on`=1 for `CS_GAP` full sck pulses, then IDLE.
- **Address wrap:** the address is not incremented by the controller. Wrap past 0xFFFFFF is the device's concern.
- **Reset mid-transaction:** on the cycle after `rst_in`=0, all outputs take their reset values. The INIT sequence restarts on release. No ack is produced for the aborted request.

## Timing
- **Reset values:**
  - `sck_o`=0, `cs_on`=1, `io_o`=0000, `io_oe_o`=0000.
  - `ack_o`=0, `rdat_o`=0.
- **Request acceptance.** Call cycle 0 the `clk_i` cycle in IDLE where `req_i`=1 is seen.
  - `cs_on` is low from cycle 1, with the first command bit valid.
  - `sck_o` first rises at cycle 2.
- **Read latency:** N sck = 8+6+`DUMMY_CYCLES`+2(`len_i`+1). `ack_o` is at cycle 1+2N.
  - `len_i`=3: ack at cycle 57.
  - `len_i`=0: ack at cycle 45.
- **Write latency:** N sck = 8+6+2(`len_i`+1). `ack_o` is at cycle 1+2N.
  - `len_i`=0: ack at cycle 33.
  - `len_i`=3: ack at cycle 45.
- **Next request:** the earliest next acceptance is 2·`CS_GAP` cycles after ack. A request held high during GAP is taken at the first IDLE cycle.
- **INIT:** `cs_on` is low for 16 cycles after reset release, then GAP.
- **Output timing:** `io_o` and `io_oe_o` change only in L-phase cycles. `cs_on` changes only while `sck_o`=0.

## Test plan
- **Reset release, unlock.** Release reset and capture IO on each sck rise. Required:
  - `io_o[0]` carries 0,0,1,1,0,1,0,1 with `io_oe_o`=0001.
  - `cs_on` returns high, followed by 2 sck pulses.
  - No ack.
- **4-byte write.** Write `adr_i`=0x000010, `len_i`=3, `wdat_i`=0xDEADBEEF. Required:
  - Command 0x38 on io0.
  - Address nibbles 0,0,0,0,1,0.
  - Data nibbles E,F,B,E,A,D,D,E.
  - `ack_o` at cycle 45.
  - The PSRAM model holds 0xEF,0xBE,0xAD,0xDE at 0x10–0x13.
- **4-byte read-back.** Read back the same address with the model attached. Required:
  - Command 0xEB.
  - 6 dummy sck with `io_oe_o`=0000.
  - `rdat_o`=0xDEADBEEF, with `ack_o` at cycle 57.
- **1-byte read.** Read 0x000012 with `len_i`=0. Required: `rdat_o`=0x000000AD, with ack at cycle 45.
- **Back-to-back requests.** Keep `req_i` high for two requests. Required:
  - The second `cs_on` fall comes exactly 2·`CS_GAP`+1 cycles after the first ack.
  - Exactly one ack per request.
- **Reset mid-read.** Assert reset mid-read, during ADR. Required:
  - Next cycle: `cs_on`=1 and `io_oe_o`=0.
  - No ack.
  - The 0x35 unlock is resent after release, and a subsequent read returns correct data.

Source files
------------

// File: rtl/qspi_psram_ctrl_if.sv
// qspi_psram_ctrl_if: request/ack bus between the SoC adapter and the PSRAM controller
interface qspi_psram_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [23:0] adr_i;
  logic [1:0]  len_i;
  logic [31:0] wdat_i;
  logic        ack_o;
  logic [31:0] rdat_o;
  modport master (output req_i, we_i, adr_i, len_i, wdat_i, input ack_o, rdat_o);
  modport slave (input req_i, we_i, adr_i, len_i, wdat_i, output ack_o, rdat_o);
endinterface

// File: rtl/qspi_psram_ctrl.sv
// qspi_psram_ctrl: quad-SPI PSRAM initiator, sends quad-enable after reset then serves 1-4 byte reads/writes
module qspi_psram_ctrl #(
  parameter int CS_GAP       = 2,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic       clk_i,
  input  logic       rst_in,
  qspi_psram_ctrl_if.slave bus,
  output logic       sck_o,
  output logic       cs_on,
  output logic [3:0] io_o,
  output logic [3:0] io_oe_o,
  input  logic [3:0] io_i
);
  typedef enum logic [2:0] {INIT, IDLE, CMD, ADR, DUMMY, WDATA, RDATA, GAP} state_t;
  localparam logic [7:0] QUAD_EN = 8'h35;
  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d, last;
  logic        we, we_d;
  logic [23:0] adr, adr_d, adr_sh;
  logic [1:0]  len, len_d;
  logic [31:0] wdat, wdat_d, rdat_d;
  logic        rise, sck_d, cs_d, ack_d;
  logic [3:0]  io_d, oe_d;
  logic [7:0]  cmd;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we;
    adr_d   = adr;
    len_d   = len;
    wdat_d  = wdat;
    rdat_d  = bus.rdat_o;
    ack_d   = 1'b0;
    // INIT with cs still high is the single setup cycle right after reset release
    rise    = !sck_o && state != IDLE && !(state == INIT && cs_on);
    sck_d   = rise;
    last    = state inside {INIT, CMD} ? 6'd7 :
              state == ADR ? 6'd5 :
              state == DUMMY ? 6'(DUMMY_CYCLES - 1) :
              state == GAP ? 6'(CS_GAP - 1) : {3'b000, len, 1'b1};
    if (state == IDLE && bus.req_i) begin
      state_d = CMD;
      cnt_d   = '0;
      we_d    = bus.we_i;
      adr_d   = bus.adr_i;
      len_d   = bus.len_i;
      wdat_d  = bus.wdat_i;
      rdat_d  = '0;
    end
    if (rise && state == RDATA) rdat_d[{cnt[2:1], ~cnt[0], 2'b00} +: 4] = io_i;
    if (sck_o) begin
      cnt_d = cnt + 6'd1;
      if (cnt == last) begin
        cnt_d   = '0;
        state_d = state == INIT ? GAP :
                  state == CMD ? ADR :
                  state == ADR ? (we ? WDATA : DUMMY) :
                  state == DUMMY ? RDATA :
                  state == GAP ? IDLE : GAP;
        ack_d   = state inside {WDATA, RDATA};
      end
    end
    cs_d   = state_d inside {IDLE, GAP};
    cmd    = we_d ? 8'h38 : 8'hEB;
    adr_sh = adr_d << {cnt_d[2:0], 2'b00};
    io_d   = 4'h0;
    oe_d   = 4'h0;
    // pad values follow the next state/index, so they only move on L-phase edges
    case (state_d)
      INIT: begin
        io_d = {3'b000, QUAD_EN[~cnt_d[2:0]]};
        oe_d = 4'b0001;
      end
      CMD: begin
        io_d = {3'b000, cmd[~cnt_d[2:0]]};
        oe_d = 4'b0001;
      end
      ADR: begin
        io_d = adr_sh[23:20];
        oe_d = 4'b1111;
      end
      WDATA: begin
        io_d = wdat_d[{cnt_d[2:1], ~cnt_d[0], 2'b00} +: 4];
        oe_d = 4'b1111;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state      <= INIT;
      cnt        <= '0;
      we         <= 1'b0;
      adr        <= '0;
      len        <= '0;
      wdat       <= '0;
      sck_o      <= 1'b0;
      cs_on      <= 1'b1;
      io_o       <= '0;
      io_oe_o    <= '0;
      bus.ack_o  <= 1'b0;
      bus.rdat_o <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      we         <= we_d;
      adr        <= adr_d;
      len        <= len_d;
      wdat       <= wdat_d;
      sck_o      <= sck_d;
      cs_on      <= cs_d;
      io_o       <= io_d;
      io_oe_o    <= oe_d;
      bus.ack_o  <= ack_d;
      bus.rdat_o <= rdat_d;
    end
  end
endmodule
